// File: rtl/scan_ctrl_shifter.sv
// Serial scan front end for the odometer control latch: shifts a frame in,
// checks length/parity, then presents CTRL_OUT followed by a clean LOAD pulse.
module scan_ctrl_shifter #(
  parameter int WIDTH          = 5,
  parameter int PARITY_EN      = 1,
  parameter int LOAD_PULSE_CYC = 2
) (
  input  logic             SCAN_CLK,
  input  logic             RESET,
  input  logic             SCAN_EN,
  input  logic             SCAN_IN,
  output logic             SCAN_OUT,
  output logic [0:WIDTH-1] CTRL_OUT,
  output logic             LOAD,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int FRAME_LEN = WIDTH + PARITY_EN;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int PC_W      = $clog2(LOAD_PULSE_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(LOAD_PULSE_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETUP,
    ST_PULSE
  } state_t;

  state_t                 state_q,   state_d;
  logic [0:FRAME_LEN-1]   sr_q,      sr_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [PC_W-1:0]        pcnt_q,    pcnt_d;
  logic                   en_prev_q, en_prev_d;
  logic [0:WIDTH-1]       ctrl_q,    ctrl_d;
  logic                   load_q,    load_d;
  logic                   busy_q,    busy_d;
  logic                   err_q,     err_d;

  logic                   parity_ok;
  logic                   frame_ok;
  logic [0:FRAME_LEN-1]   sr_shifted;
  logic [CNT_W-1:0]       cnt_inc;

  always_comb begin
    parity_ok  = (PARITY_EN == 0) || !(^sr_q);
    frame_ok   = (cnt_q == CNT_FULL) && parity_ok;
    sr_shifted = {sr_q[1:FRAME_LEN-1], SCAN_IN};
    // Saturate one past a full frame so overlong frames can never wrap to valid.
    cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // below can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    err_d     = err_q;
    en_prev_d = SCAN_EN;

    unique case (state_q)
      ST_IDLE: begin
        // Only a fresh rising SCAN_EN starts a frame; a level held high is ignored.
        if (SCAN_EN && !en_prev_q) begin
          sr_d    = sr_shifted;
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (SCAN_EN) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_inc;
        end else begin
          cnt_d = '0;
          if (frame_ok) begin
            ctrl_d  = sr_q[0:WIDTH-1];
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SETUP: begin
        if (SCAN_EN) err_d = 1'b1;
        load_d  = 1'b1;
        pcnt_d  = PC_W'(1);
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (SCAN_EN) err_d = 1'b1;
        if (pcnt_q == PC_LAST) begin
          load_d  = 1'b0;
          pcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the shift register is reset too, since SCAN_OUT must
  // read 0 straight out of reset.
  always_ff @(posedge SCAN_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      en_prev_q <= 1'b0;
      ctrl_q    <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      en_prev_q <= en_prev_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign SCAN_OUT  = sr_q[0];
  assign CTRL_OUT  = ctrl_q;
  assign LOAD      = load_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_scan_ctrl_shifter.sv
// Bench for scan_ctrl_shifter: directed frame table, corner-case sequences and
// random frames checked against a queue-based frame model.
module tb_scan_ctrl_shifter;

  localparam int W   = 5;
  localparam int PE  = 1;
  localparam int LPC = 2;
  localparam int FL  = W + PE;

  logic           clk = 1'b0;
  logic           rst;
  logic           scan_en;
  logic           scan_in;
  logic           scan_out;
  logic [0:W-1]   ctrl_out;
  logic           load;
  logic           busy;
  logic           frame_err;

  int total = 0;
  int bad   = 0;

  scan_ctrl_shifter #(
    .WIDTH(W), .PARITY_EN(PE), .LOAD_PULSE_CYC(LPC)
  ) dut (
    .SCAN_CLK (clk),
    .RESET    (rst),
    .SCAN_EN  (scan_en),
    .SCAN_IN  (scan_in),
    .SCAN_OUT (scan_out),
    .CTRL_OUT (ctrl_out),
    .LOAD     (load),
    .BUSY     (busy),
    .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  // Frame-level model: history of the last FL sampled bits, current frame
  // length, and edges elapsed since a valid commit (-1 when none pending).
  bit           m_hist[$];
  int           m_len;
  bit           m_in_frame;
  int           m_t;
  bit           m_prev;
  logic [0:W-1] m_ctrl;
  bit           m_err, m_load, m_busy;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < FL; i++) m_hist.push_back(1'b0);
    m_len = 0; m_in_frame = 0; m_t = -1; m_prev = 0;
    m_ctrl = '0; m_err = 0; m_load = 0; m_busy = 0;
  endfunction

  function automatic void model_push(bit b);
    void'(m_hist.pop_front());
    m_hist.push_back(b);
    if (m_len < 1000) m_len++;
  endfunction

  function automatic void model_edge(bit en, bit din);
    int ones;
    if (m_t >= 0) begin
      m_t++;
      if (en) m_err = 1;
      if (m_t > LPC) m_t = -1;
    end else if (m_in_frame) begin
      if (en) model_push(din);
      else begin
        m_in_frame = 0;
        ones = 0;
        foreach (m_hist[i]) ones += int'(m_hist[i]);
        if (m_len == FL && (PE == 0 || ones % 2 == 0)) begin
          for (int i = 0; i < W; i++) m_ctrl[i] = m_hist[i];
          m_err = 0;
          m_t   = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (en && !m_prev) begin
      m_in_frame = 1;
      m_len      = 0;
      model_push(din);
    end
    m_prev = en;
    m_load = (m_t >= 1 && m_t <= LPC);
    m_busy = m_in_frame || (m_t >= 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("mdl_ctrl", 32'(ctrl_out), 32'(m_ctrl));
    check("mdl_load", 32'(load), 32'(m_load));
    check("mdl_busy", 32'(busy), 32'(m_busy));
    check("mdl_err", 32'(frame_err), 32'(m_err));
    check("mdl_scan_out", 32'(scan_out), 32'(m_hist[0]));
  endtask

  task automatic step(input bit en, input bit din);
    scan_en = en;
    scan_in = din;
    @(posedge clk);
    model_edge(en, din);
    #1;
    compare_model();
  endtask

  // Sends v[n-1] first and v[0] last, leaving SCAN_EN high.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 32'(ctrl_out), 32'd0);
    check({tag, "_load"}, 32'(load), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_scan_out"}, 32'(scan_out), 32'd0);
  endtask

  // Asserts RESET between edges and checks outputs before any clock edge.
  task automatic mid_reset(input string tag);
    scan_en = 1'b0;
    scan_in = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit           en;
    bit           din;
    logic [0:W-1] ctrl;
    bit           load;
    bit           busy;
    bit           err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          len;
    bit          p;

    // Frame 1,0,1,1,0 + parity 1; edge k is row 6.
    tbl[0] = '{1, 1, 5'b00000, 0, 1, 0};
    tbl[1] = '{1, 0, 5'b00000, 0, 1, 0};
    tbl[2] = '{1, 1, 5'b00000, 0, 1, 0};
    tbl[3] = '{1, 1, 5'b00000, 0, 1, 0};
    tbl[4] = '{1, 0, 5'b00000, 0, 1, 0};
    tbl[5] = '{1, 1, 5'b00000, 0, 1, 0};
    tbl[6] = '{0, 0, 5'b10110, 0, 1, 0};
    tbl[7] = '{0, 0, 5'b10110, 1, 1, 0};
    tbl[8] = '{0, 0, 5'b10110, 1, 1, 0};
    tbl[9] = '{0, 0, 5'b10110, 0, 0, 0};

    scan_en = 1'b0;
    scan_in = 1'b0;
    rst     = 1'b1;
    model_reset();
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Valid frame, table driven.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].din);
      check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_out), 32'(tbl[i].ctrl));
      check($sformatf("tbl%0d_load", i), 32'(load), 32'(tbl[i].load));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
    end

    // Bad parity, then a valid frame clears the error.
    send_bits(32'b101100, 6);
    step(1'b0, 1'b0);
    check("par_err", 32'(frame_err), 32'd1);
    check("par_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("par_noload", 32'(load), 32'd0);
    end
    check("par_ctrl_held", 32'(ctrl_out), 32'(5'b10110));
    send_bits(32'b010010, 6);
    step(1'b0, 1'b0);
    check("par_clear_err", 32'(frame_err), 32'd0);
    check("par_new_ctrl", 32'(ctrl_out), 32'(5'b01001));
    idle(3);

    // Short and long frames.
    send_bits(32'b1111, 4);
    step(1'b0, 1'b0);
    check("short_err", 32'(frame_err), 32'd1);
    step(1'b0, 1'b0);
    check("short_noload", 32'(load), 32'd0);
    check("short_ctrl", 32'(ctrl_out), 32'(5'b01001));
    send_bits(32'b110000, 6);
    idle(4);
    check("mid_ctrl", 32'(ctrl_out), 32'(5'b11000));
    check("mid_err", 32'(frame_err), 32'd0);
    send_bits(32'b1011010, 7);
    step(1'b0, 1'b0);
    check("long_err", 32'(frame_err), 32'd1);
    check("long_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("long_noload", 32'(load), 32'd0);
    end
    check("long_ctrl", 32'(ctrl_out), 32'(5'b11000));

    // Reset mid-frame, then a normal frame.
    send_bits(32'b101, 3);
    mid_reset("rst_frame");
    step(1'b0, 1'b0);
    send_bits(32'b001111, 6);
    step(1'b0, 1'b0);
    check("post_rst_ctrl", 32'(ctrl_out), 32'(5'b00111));
    step(1'b0, 1'b0);
    check("post_rst_load", 32'(load), 32'd1);
    idle(2);
    check("post_rst_idle", 32'(busy), 32'd0);

    // SCAN_EN during PULSE, then SCAN_OUT replays the previous frame.
    send_bits(32'b110011, 6);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("pulse_load1", 32'(load), 32'd1);
    step(1'b1, 1'b0);
    check("pulse_load2", 32'(load), 32'd1);
    check("pulse_err", 32'(frame_err), 32'd1);
    step(1'b1, 1'b1);
    check("pulse_load_end", 32'(load), 32'd0);
    check("pulse_busy_end", 32'(busy), 32'd0);
    step(1'b1, 1'b1);
    check("pulse_nostart", 32'(busy), 32'd0);
    check("pulse_ctrl_held", 32'(ctrl_out), 32'(5'b11001));
    step(1'b0, 1'b0);
    v = 32'b110011;
    for (int i = 0; i < FL; i++) begin
      check($sformatf("replay%0d", i), 32'(scan_out), 32'(v[FL-1-i]));
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    check("replay_ctrl", 32'(ctrl_out), 32'(5'b00000));
    check("replay_err_clr", 32'(frame_err), 32'd0);

    // Reset while LOAD is high.
    idle(1);
    check("rp_load", 32'(load), 32'd1);
    mid_reset("rst_pulse");

    // Random frames of varying length, parity and spacing.
    for (int f = 0; f < 300; f++) begin
      v   = $urandom;
      len = ($urandom_range(0, 9) < 6) ? FL : int'($urandom_range(1, FL + 3));
      if (len == FL && $urandom_range(0, 3) != 0) begin
        p = 0;
        for (int i = 1; i < len; i++) p ^= v[i];
        v[0] = p;
      end
      send_bits(v, len);
      idle(int'($urandom_range(1, 5)));
      if ($urandom_range(0, 39) == 0) mid_reset("rand_rst");
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
